// File: rtl/add_seq16_if.sv
// Operand/result stream bundle for add_seq16, including the full-result flags.
// The sub signal exists only when ADD_SEQ_SUB_EN is defined.
interface add_seq16_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic        out_last;
   logic        flags_valid;
   logic        sign;
   logic        zero;
   logic        carry;
   logic        parity;
   logic        overflow;
`ifdef ADD_SEQ_SUB_EN
   logic        sub;
`endif

   modport master (
      output in_valid, in_a, in_b, out_ready,
`ifdef ADD_SEQ_SUB_EN
      output sub,
`endif
      input  in_ready, out_valid, out_sum, out_last,
      input  flags_valid, sign, zero, carry, parity, overflow
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
`ifdef ADD_SEQ_SUB_EN
      input  sub,
`endif
      output in_ready, out_valid, out_sum, out_last,
      output flags_valid, sign, zero, carry, parity, overflow
   );
endinterface

// File: rtl/add_seq16.sv
// Multi-precision add sequencer: WORDS x 16-bit operands, LS word first, carry chained.
// Define ADD_SEQ_SUB_EN to add the sub input (A - B via inverted B and carry-in 1).
module add_seq16 #(
   parameter int unsigned WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   add_seq16_if.slave  bus
);
   localparam int unsigned IDX_W = $clog2(WORDS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             cy_q, cy_d;
   logic             zacc_q, zacc_d;
   logic             pacc_q, pacc_d;
   logic             out_valid_q, out_valid_d;
   logic [15:0]      out_sum_q, out_sum_d;
   logic             out_last_q, out_last_d;
   logic             fv_q, fv_d;
   logic             sign_q, sign_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;
   logic             parity_q, parity_d;
   logic             ovf_q, ovf_d;
`ifdef ADD_SEQ_SUB_EN
   logic             sub_q, sub_d;
`endif

   logic        accept;
   logic        first;
   logic        last;
   logic        sub_eff;
   logic        cin;
   logic [15:0] b_eff;
   logic [16:0] sum;
   logic        s_zero;
   logic        s_par;

   assign bus.in_ready = ~out_valid_q | bus.out_ready;
   assign accept       = bus.in_valid & bus.in_ready;
   assign first        = (state_q == IDLE);
   assign last         = (idx_q == IDX_LAST);

   // Effective operand B and carry-in for the current word
   always_comb begin
      sub_eff = 1'b0;
`ifdef ADD_SEQ_SUB_EN
      sub_eff = first ? bus.sub : sub_q;
`endif
      b_eff  = sub_eff ? ~bus.in_b : bus.in_b;
      cin    = first ? sub_eff : cy_q;
      sum    = 17'(bus.in_a) + 17'(b_eff) + 17'(cin);
      s_zero = (sum[15:0] == 16'h0000);
      s_par  = ^sum[15:0];
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cy_d        = cy_q;
      zacc_d      = zacc_q;
      pacc_d      = pacc_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_last_d  = out_last_q;
      fv_d        = fv_q;
      sign_d      = sign_q;
      zero_d      = zero_q;
      carry_d     = carry_q;
      parity_d    = parity_q;
      ovf_d       = ovf_q;
`ifdef ADD_SEQ_SUB_EN
      sub_d       = sub_q;
`endif
      if (accept) begin
         out_valid_d = 1'b1;
         out_sum_d   = sum[15:0];
         out_last_d  = last;
         cy_d        = sum[16];
         zacc_d      = first ? s_zero : (zacc_q & s_zero);
         pacc_d      = first ? s_par : (pacc_q ^ s_par);
`ifdef ADD_SEQ_SUB_EN
         sub_d       = sub_eff;
`endif
         if (first) begin
            fv_d = 1'b0;
         end
         if (last) begin
            state_d  = IDLE;
            idx_d    = '0;
            fv_d     = 1'b1;
            sign_d   = sum[15];
            zero_d   = zacc_d;
            parity_d = ~pacc_d;
            carry_d  = sum[16];
            ovf_d    = (bus.in_a[15] & b_eff[15] & ~sum[15]) |
                       (~bus.in_a[15] & ~b_eff[15] & sum[15]);
         end else begin
            state_d = RUN;
            idx_d   = idx_q + IDX_W'(1);
         end
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         cy_q        <= 1'b0;
         zacc_q      <= 1'b0;
         pacc_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_last_q  <= 1'b0;
         fv_q        <= 1'b0;
         sign_q      <= 1'b0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         parity_q    <= 1'b0;
         ovf_q       <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
         sub_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cy_q        <= cy_d;
         zacc_q      <= zacc_d;
         pacc_q      <= pacc_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_last_q  <= out_last_d;
         fv_q        <= fv_d;
         sign_q      <= sign_d;
         zero_q      <= zero_d;
         carry_q     <= carry_d;
         parity_q    <= parity_d;
         ovf_q       <= ovf_d;
`ifdef ADD_SEQ_SUB_EN
         sub_q       <= sub_d;
`endif
      end
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.out_sum     = out_sum_q;
   assign bus.out_last    = out_last_q;
   assign bus.flags_valid = fv_q;
   assign bus.sign        = sign_q;
   assign bus.zero        = zero_q;
   assign bus.carry       = carry_q;
   assign bus.parity      = parity_q;
   assign bus.overflow    = ovf_q;
endmodule

// File: doc/add_seq16.md
# add_seq16

Multi-precision add sequencer built around the team's 16-bit add-with-flags datapath. It accepts WORDS-word operands one 16-bit word per transfer, least significant word first, and chains the carry between words. Each sum word is emitted on a registered output stream, and the Sign/Zero/Carry/Parity/Overflow flags are produced for the full-width result. It sits between a bus-side operand source and a result sink and owns the carry chain across words.

## Interface
- WORDS, 4: words per operand, legal 2..8; counter width is $clog2(WORDS).
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand word pair valid.
- in_ready  out  1  block accepts the word pair this cycle.
- in_a  in  16  operand A word.
- in_b  in  16  operand B word.
- out_valid  out  1  sum word valid.
- out_ready  in  1  sink accepts the sum word.
- out_sum  out  16  sum word.
- out_last  out  1  marks the most significant (final) sum word.
- flags_valid  out  1  flags below describe the last completed operation.
- sign, zero, carry, parity, overflow  out  1 each  full-result flags.
- sub  in  1  present only with ADD_SEQ_SUB_EN (see Configuration).

## Operation
- Accept happens when in_valid and in_ready are both high. in_ready = ~out_valid | out_ready, giving a single output register with no skid buffer.
- The word counter idx runs 0..WORDS-1.
  - idx==0 is the IDLE/first-word state.
  - The accept at idx==WORDS-1 wraps idx to 0.
- Carry chain:
  - carry-in for idx 0 is 0 (1 when subtracting).
  - For later words, carry-in is the registered carry-out of the previous word.
  - {cout, s} = in_a + in_b + cin, computed at 17 bits.
- Running flag accumulators:
  - zacc &= (s==0)
  - pacc ^= ^s
  - Both are re-seeded at idx 0 from the current word alone.
- On the final-word accept, the following are loaded. All flags reflect the whole WORDS×16-bit result:
  - sign = s[15]
  - zero = zacc_next
  - parity = ~pacc_next (even parity; 1 when the count of ones is even)
  - carry = cout
  - overflow = (a15 & b15 & ~s15) | (~a15 & ~b15 & s15), using the effective (possibly inverted) B.
- flags_valid sets on the final-word accept. It clears on the next idx-0 accept. The flag values hold until the next final-word accept.
- States:
  - IDLE (idx 0, no op in flight)
  - RUN (0 < idx < WORDS)
  - Transition IDLE→RUN on accept; RUN→IDLE on accepting word WORDS-1.
  - There is no abort input; only rst aborts an operation.
- Simultaneous events: the final output can be consumed in the same cycle the next op's first word is accepted. Full throughput is one word per cycle.

## Timing
- Latency: out_valid rises 1 cycle after accept, and out_sum/out_last are registered.
- While out_valid && !out_ready: out_sum, out_last and out_valid hold stable, and in_ready is low.
- flags_valid and the flags update in the same edge that presents the last word (out_last=1).
- Reset values (asynchronous, immediate):
  - out_valid=0, out_sum=0, out_last=0
  - flags_valid=0, sign=0, zero=0, carry=0, parity=0, overflow=0
  - idx=0, internal carry=0
  - in_ready=1 (combinational from out_valid=0).
- Reset mid-operation discards the partial op. The next accept is treated as word 0.

## Configuration
- ADD_SEQ_SUB_EN defined:
  - The sub port exists and is sampled only on the idx-0 accept, then held for the op.
  - When sub=1, in_b is inverted and word-0 carry-in is 1, so the block computes A−B.
  - carry=1 means no borrow. overflow uses the inverted B's MSB.
- ADD_SEQ_SUB_EN undefined:
  - There is no sub port and the block performs addition only.
  - Word-0 carry-in is hard 0.

## Test plan
- WORDS=4, A=0x0000_0000_0000_FFFF, B=0x0000_0000_0000_0001, out_ready=1 → out_sum 0x0000, 0x0001, 0x0000, 0x0000 on consecutive cycles; out_last on the 4th word; carry=0, zero=0, parity=0, sign=0, overflow=0.
- A=all 0xFFFF, B=0x0000_0000_0000_0001 → four 0x0000 words; carry=1, zero=1, parity=1, overflow=0, sign=0.
- A=0x7FFF_FFFF_FFFF_FFFF, B=1 → 0x0000, 0x0000, 0x0000, 0x8000; overflow=1, sign=1, carry=0.
- Hold out_ready=0 for 3 cycles after word 1 → in_ready=0 and out_sum stable for those cycles; completion is delayed by exactly 3 cycles with the result unchanged.
- Assert rst after 2 words are accepted → all outputs at their reset values; the next 4-word op 1+1 yields 0x0002, 0, 0, 0 (no stale carry) with flags_valid=1.
- ADD_SEQ_SUB_EN, sub=1, A=0, B=1 → four 0xFFFF words; carry=0, sign=1, overflow=0, zero=0, parity=1.
